// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one SRAM controller; round-robin or fixed priority (FIXED_PRIO).
// Define SRAM_ARB_TIMEOUT_EN to bound WAIT at TIMEOUT cycles and report aborts on err_o.
module sram_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned TIMEOUT    = 31
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] wdata0_i,
  output logic          ack0_o,
  output logic [DW-1:0] rdata0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          ack1_o,
  output logic [DW-1:0] rdata1_o,
  output logic          err_o,
  output logic          busy_o,
  output logic          gnt_o,
  output logic          sram_rd_en_o,
  output logic          sram_wr_en_o,
  output logic [AW-1:0] sram_address_o,
  output logic [DW-1:0] sram_wdata_o,
  input  logic [DW-1:0] sram_rdata_i,
  input  logic          sram_ready_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err_q, err_d, busy_q, busy_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          pick, timeout_hit, rd_done;

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("sram_arbiter: TIMEOUT must be at least 1");
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // cnt_q == TIMEOUT-1 marks the TIMEOUT-th WAIT cycle.
  assign timeout_hit = (state_q == StWait) && !sram_ready_i &&
                       (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Port 1 wins when alone, or on a tie when round-robin and port 0 was served last.
  assign pick    = req1_i && (!req0_i || (!FIXED_PRIO && !last_q));
  assign rd_done = (state_q == StWait) && sram_ready_i && !we_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (sram_ready_i && (req0_i || req1_i)) begin
          state_d = StIssue;
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? we1_i : we0_i;
          addr_d  = pick ? addr1_i : addr0_i;
          wdata_d = pick ? wdata1_i : wdata0_i;
        end
      end
      StIssue: state_d = StWait;
      StWait:  if (sram_ready_i || timeout_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_en_d  = (state_d == StIssue) && !we_d;
    wr_en_d  = (state_d == StIssue) && we_d;
    ack0_d   = (state_d == StDone) && !gnt_d;
    ack1_d   = (state_d == StDone) && gnt_d;
    err_d    = (state_d == StDone) && timeout_hit;
    busy_d   = (state_d != StIdle);
    rdata0_d = (rd_done && !gnt_q) ? sram_rdata_i : rdata0_q;
    rdata1_d = (rd_done && gnt_q) ? sram_rdata_i : rdata1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0_o         = ack0_q;
  assign ack1_o         = ack1_q;
  assign rdata0_o       = rdata0_q;
  assign rdata1_o       = rdata1_q;
  assign err_o          = err_q;
  assign busy_o         = busy_q;
  assign gnt_o          = gnt_q;
  assign sram_rd_en_o   = rd_en_q;
  assign sram_wr_en_o   = wr_en_q;
  assign sram_address_o = addr_q;
  assign sram_wdata_o   = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench: a behavioural SRAM controller serves the round-robin DUT while a
// fixed-priority twin runs in lockstep on the same inputs.
module tb_sram_arbiter;
  localparam int unsigned TIMEOUT = 31;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        sram_ready;
  logic [31:0] sram_rdata;

  logic        ack0, ack1, err, busy, gnt, rd_en, wr_en;
  logic [31:0] rdata0, rdata1, s_addr, s_wdata;
  logic        fp_ack0, fp_ack1, fp_err, fp_busy, fp_gnt, fp_rd_en, fp_wr_en;
  logic [31:0] fp_rdata0, fp_rdata1, fp_s_addr, fp_s_wdata;

  int checks = 0;
  int failures = 0;

  // Controller model knobs and storage.
  int          ctrl_n = 6;
  bit          ctrl_hang = 1'b0;
  logic [31:0] ctl_mem [logic [31:0]];

  // Reference model state.
  logic [31:0] ref_mem [logic [31:0]];
  bit          m_last = 1'b1;
  logic [31:0] m_rdata0 = '0;
  logic [31:0] m_rdata1 = '0;

  // Observations of one transaction.
  int          o_issue, o_en, o_ack, o_port, o_fp_port;
  bit          o_both_en, o_wr, o_err, o_gnt;
  logic [31:0] o_addr, o_wdata;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1'b0), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .ack0_o(ack0), .rdata0_o(rdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .ack1_o(ack1), .rdata1_o(rdata1),
    .err_o(err), .busy_o(busy), .gnt_o(gnt),
    .sram_rd_en_o(rd_en), .sram_wr_en_o(wr_en), .sram_address_o(s_addr),
    .sram_wdata_o(s_wdata), .sram_rdata_i(sram_rdata), .sram_ready_i(sram_ready)
  );

  sram_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1'b1), .TIMEOUT(TIMEOUT)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .ack0_o(fp_ack0), .rdata0_o(fp_rdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .ack1_o(fp_ack1), .rdata1_o(fp_rdata1),
    .err_o(fp_err), .busy_o(fp_busy), .gnt_o(fp_gnt),
    .sram_rd_en_o(fp_rd_en), .sram_wr_en_o(fp_wr_en), .sram_address_o(fp_s_addr),
    .sram_wdata_o(fp_s_wdata), .sram_rdata_i(sram_rdata), .sram_ready_i(sram_ready)
  );

  function automatic logic [31:0] fill(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ctl_read(input logic [31:0] a);
    return ctl_mem.exists(a) ? ctl_mem[a] : fill(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  // Round-robin rule: a lone requester wins; on a tie the port not served last wins.
  function automatic int rr_winner(input bit r0, input bit r1);
    if (r0 && r1) return (m_last == 1'b1) ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  task automatic model_commit(input int p, input bit w, input logic [31:0] a,
                              input logic [31:0] d);
    m_last = (p == 1);
    if (w) ref_mem[a] = d;
    else if (p == 1) m_rdata1 = ref_read(a);
    else m_rdata0 = ref_read(a);
  endtask

  // Behavioural controller: samples an enable, drops ready for ctrl_n cycles, then answers.
  initial begin
    logic        c_we;
    logic [31:0] c_addr, c_wdata;
    int          cnt;
    sram_ready = 1'b1;
    sram_rdata = '0;
    forever begin
      @(negedge clk);
      if (rd_en || wr_en) begin
        c_we = wr_en;
        c_addr = s_addr;
        c_wdata = s_wdata;
        @(posedge clk);
        #1;
        sram_ready = 1'b0;
        if (c_we) ctl_mem[c_addr] = c_wdata;
        cnt = 0;
        while (ctrl_hang || cnt < ctrl_n) begin
          @(posedge clk);
          cnt++;
        end
        #1;
        sram_rdata = c_we ? $urandom : ctl_read(c_addr);
        sram_ready = 1'b1;
      end
    end
  end

  task automatic observe(input int bound);
    o_issue = -1; o_en = 0; o_both_en = 1'b0; o_ack = -1; o_port = -1; o_fp_port = -1;
    o_err = 1'b0; o_wr = 1'b0; o_gnt = 1'b0; o_addr = '0; o_wdata = '0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (rd_en || wr_en) begin
        o_en++;
        if (rd_en && wr_en) o_both_en = 1'b1;
        if (o_issue < 0) begin
          o_issue = c; o_wr = wr_en; o_addr = s_addr; o_wdata = s_wdata;
        end
      end
      if (fp_ack0 || fp_ack1) o_fp_port = fp_ack1 ? 1 : 0;
      if (ack0 || ack1) begin
        o_ack = c;
        o_port = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        o_err = err;
        o_gnt = gnt;
        break;
      end
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60 && !sram_ready; i++) @(negedge clk);
    checks++;
    if (sram_ready !== 1'b1) begin
      failures++; $display("FAIL ready_wait: got %b required 1", sram_ready);
    end
  endtask

  task automatic test_reset();
    logic [134:0] snap;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    snap = {ack0, ack1, err, busy, gnt, rd_en, wr_en, s_addr, s_wdata, rdata0, rdata1};
    checks++;
    if (snap !== '0) begin failures++; $display("FAIL reset_outputs: got %h required 0", snap); end
    snap = {fp_ack0, fp_ack1, fp_err, fp_busy, fp_gnt, fp_rd_en, fp_wr_en, fp_s_addr,
            fp_s_wdata, fp_rdata0, fp_rdata1};
    checks++;
    if (snap !== '0) begin failures++; $display("FAIL reset_fp_outputs: got %h required 0", snap); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    ctrl_n = 6;
    ctl_mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = $urandom;
    observe(60);
    req0 = 1'b0;
    model_commit(0, 1'b0, 32'h10, '0);
    checks++;
    if (o_en !== 1) begin failures++; $display("FAIL read_en_pulses: got %0d required 1", o_en); end
    checks++;
    if (o_wr !== 1'b0) begin failures++; $display("FAIL read_is_rd: got wr=%b required 0", o_wr); end
    checks++;
    if (o_addr !== 32'h10) begin failures++; $display("FAIL read_addr: got %h required 10", o_addr); end
    checks++;
    if (o_ack !== 9) begin failures++; $display("FAIL read_latency: got %0d required 9", o_ack); end
    checks++;
    if (o_port !== 0) begin failures++; $display("FAIL read_ack_port: got %0d required 0", o_port); end
    checks++;
    if (rdata0 !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL read_rdata0: got %h required deadbeef", rdata0);
    end
    checks++;
    if (rdata1 !== m_rdata1) begin
      failures++; $display("FAIL read_rdata1_held: got %h required %h", rdata1, m_rdata1);
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    ctrl_n = 6;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
    observe(60);
    req1 = 1'b0;
    model_commit(1, 1'b1, 32'h20, 32'h1234_5678);
    checks++;
    if (o_en !== 1 || o_both_en !== 1'b0) begin
      failures++; $display("FAIL write_en_pulses: got %0d both=%b required 1 both=0", o_en, o_both_en);
    end
    checks++;
    if (o_wr !== 1'b1) begin failures++; $display("FAIL write_is_wr: got wr=%b required 1", o_wr); end
    checks++;
    if (o_wdata !== 32'h1234_5678 || o_addr !== 32'h20) begin
      failures++; $display("FAIL write_bus: got %h@%h required 12345678@20", o_wdata, o_addr);
    end
    checks++;
    if (o_port !== 1 || o_ack !== 9) begin
      failures++; $display("FAIL write_ack: got port %0d cyc %0d required 1/9", o_port, o_ack);
    end
    checks++;
    if (o_err !== 1'b0) begin failures++; $display("FAIL write_err: got %b required 0", o_err); end
    checks++;
    if (rdata1 !== m_rdata1) begin
      failures++; $display("FAIL write_rdata1_held: got %h required %h", rdata1, m_rdata1);
    end
  endtask

  task automatic test_round_robin();
    int exp_port;
    @(negedge clk);
    ctrl_n = $urandom_range(2, 7);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h104;
    for (int k = 0; k < 4; k++) begin
      exp_port = rr_winner(1'b1, 1'b1);
      observe(60);
      model_commit(exp_port, 1'b0, exp_port == 1 ? 32'h104 : 32'h100, '0);
      checks++;
      if (o_port !== exp_port || o_gnt !== exp_port[0]) begin
        failures++;
        $display("FAIL rr_grant%0d: got port %0d gnt %b required %0d", k, o_port, o_gnt, exp_port);
      end
      checks++;
      if (o_fp_port !== 0) begin
        failures++; $display("FAIL fp_grant%0d: got %0d required 0", k, o_fp_port);
      end
      checks++;
      if (o_ack !== ((k == 0) ? ctrl_n + 3 : ctrl_n + 4)) begin
        failures++;
        $display("FAIL rr_period%0d: got %0d required %0d", k, o_ack,
                 (k == 0) ? ctrl_n + 3 : ctrl_n + 4);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (rdata0 !== m_rdata0 || rdata1 !== m_rdata1) begin
      failures++;
      $display("FAIL rr_rdata: got %h/%h required %h/%h", rdata0, rdata1, m_rdata0, m_rdata1);
    end
  endtask

  task automatic test_ready_low_idle();
    int bad;
    @(negedge clk);
    ctrl_n = 4;
    sram_ready = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h44;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rd_en || wr_en || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL ready_low_hold: got %0d active cycles required 0", bad); end
    sram_ready = 1'b1;
    observe(60);
    req0 = 1'b0;
    model_commit(0, 1'b0, 32'h44, '0);
    checks++;
    if (o_issue !== 1) begin failures++; $display("FAIL ready_rise_issue: got %0d required 1", o_issue); end
    checks++;
    if (o_ack !== ctrl_n + 3 || rdata0 !== m_rdata0) begin
      failures++;
      $display("FAIL ready_rise_done: got %0d/%h required %0d/%h", o_ack, rdata0, ctrl_n + 3, m_rdata0);
    end
  endtask

  task automatic test_random();
    bit [1:0]    pat;
    int          win, fpw;
    bit          w;
    logic [31:0] a, d;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ctrl_n = $urandom_range(1, 8);
      pat = 2'($urandom_range(1, 3));
      req0 = pat[0]; we0 = 1'($urandom_range(0, 1));
      addr0 = 32'h200 + 32'($urandom_range(0, 7)) * 4; wdata0 = $urandom;
      req1 = pat[1]; we1 = 1'($urandom_range(0, 1));
      addr1 = 32'h200 + 32'($urandom_range(0, 7)) * 4; wdata1 = $urandom;
      win = rr_winner(pat[0], pat[1]);
      fpw = pat[0] ? 0 : 1;
      w = (win == 1) ? we1 : we0;
      a = (win == 1) ? addr1 : addr0;
      d = (win == 1) ? wdata1 : wdata0;
      observe(40);
      req0 = 1'b0; req1 = 1'b0;
      model_commit(win, w, a, d);
      checks++;
      if (o_port !== win || o_fp_port !== fpw) begin
        failures++;
        $display("FAIL rand%0d_port: got %0d/%0d required %0d/%0d", k, o_port, o_fp_port, win, fpw);
      end
      checks++;
      if (o_en !== 1 || o_wr !== w || o_addr !== a || (w && o_wdata !== d)) begin
        failures++;
        $display("FAIL rand%0d_bus: got en%0d wr%b %h %h required wr%b %h %h", k, o_en, o_wr,
                 o_addr, o_wdata, w, a, d);
      end
      checks++;
      if (o_ack !== ctrl_n + 3 || o_err !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_ack: got %0d err %b required %0d err 0", k, o_ack, o_err, ctrl_n + 3);
      end
      checks++;
      if (rdata0 !== m_rdata0 || rdata1 !== m_rdata1) begin
        failures++;
        $display("FAIL rand%0d_rdata: got %h/%h required %h/%h", k, rdata0, rdata1,
                 m_rdata0, m_rdata1);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [134:0] snap;
    int           acks;
    @(negedge clk);
    ctrl_n = 6;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midwait_busy: got %b required 1", busy); end
    rst_n = 1'b0;
    #1;
    snap = {ack0, ack1, err, busy, gnt, rd_en, wr_en, s_addr, s_wdata, rdata0, rdata1};
    checks++;
    if (snap !== '0) begin failures++; $display("FAIL midwait_reset: got %h required 0", snap); end
    req0 = 1'b0;
    m_last = 1'b1; m_rdata0 = '0; m_rdata1 = '0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    checks++;
    if (acks !== 0) begin failures++; $display("FAIL midwait_no_ack: got %0d required 0", acks); end
    wait_ready();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h300;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h304;
    observe(60);
    req0 = 1'b0; req1 = 1'b0;
    model_commit(0, 1'b0, 32'h300, '0);
    checks++;
    if (o_port !== 0 || o_gnt !== 1'b0 || o_fp_port !== 0) begin
      failures++; $display("FAIL post_reset_tie: got %0d gnt %b required 0", o_port, o_gnt);
    end
    checks++;
    if (rdata0 !== m_rdata0 || rdata1 !== 32'h0) begin
      failures++; $display("FAIL post_reset_rdata: got %h/%h required %h/0", rdata0, rdata1, m_rdata0);
    end
  endtask

`ifdef SRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    ctrl_hang = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    observe(100);
    req0 = 1'b0;
    m_last = 1'b0;
    checks++;
    if (o_ack !== TIMEOUT + 2 || o_port !== 0) begin
      failures++; $display("FAIL timeout_ack: got %0d port %0d required %0d port 0", o_ack, o_port,
                           TIMEOUT + 2);
    end
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL timeout_err: got %b required 1", o_err); end
    checks++;
    if (rdata0 !== m_rdata0) begin
      failures++; $display("FAIL timeout_rdata: got %h required %h", rdata0, m_rdata0);
    end
    ctrl_hang = 1'b0;
    wait_ready();
    @(negedge clk);
    ctrl_n = 3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    observe(60);
    req1 = 1'b0;
    model_commit(1, 1'b0, 32'h20, '0);
    checks++;
    if (o_ack !== 6 || o_err !== 1'b0 || rdata1 !== m_rdata1) begin
      failures++;
      $display("FAIL after_timeout: got %0d err %b %h required 6 err 0 %h", o_ack, o_err, rdata1,
               m_rdata1);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_ready_low_idle();
    test_random();
    test_reset_mid_wait();
`ifdef SRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
